// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug GPR access block.
package dbg_pkg;

  localparam int unsigned XLEN_DEFAULT = 64;
  localparam int unsigned IDX_W        = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HALT,
    ST_ACCESS,
    ST_RESP
  } state_e;

  // x0 is hardwired to zero: writes are dropped and reads return 0.
  function automatic logic is_zero_idx(input logic [IDX_W-1:0] idx);
    return idx == '0;
  endfunction

endpackage

// File: rtl/dbg_halt_timer.sv
// Counts HALT cycles spent waiting for halt_ack; flags the last allowed cycle.
module dbg_halt_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  // Asserted during the LIMIT-th consecutive un-acked HALT cycle.
  assign expired = enable && (count >= LAST);

endmodule

// File: rtl/dbg_gpr_access.sv
// Debug port access to the core GPR file: halts the core, performs one
// read or write through the existing regfile ports, then returns a response.
module dbg_gpr_access
  import dbg_pkg::*;
#(
  parameter int unsigned XLEN         = XLEN_DEFAULT,
  parameter int unsigned HALT_TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [IDX_W-1:0] cmd_idx,
  input  logic [XLEN-1:0]  cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_rdata,
  output logic             rsp_err,
  output logic             halt_req,
  input  logic             halt_ack,
  output logic [IDX_W-1:0] rf_ridx,
  input  logic [XLEN-1:0]  rf_rdata,
  output logic             rf_wen,
  output logic [IDX_W-1:0] rf_widx,
  output logic [XLEN-1:0]  rf_wdata
);

  state_e             state;
  logic               lat_write;
  logic [IDX_W-1:0]   lat_idx;
  logic [XLEN-1:0]    lat_wdata;
  logic               accept;
  logic               timer_en;
  logic               expired;

  assign accept   = (state == ST_IDLE) && cmd_valid && cmd_ready;
  assign timer_en = (state == ST_HALT) && !halt_ack;

  dbg_halt_timer #(
    .LIMIT (HALT_TIMEOUT)
  ) u_halt_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (accept),
    .enable  (timer_en),
    .expired (expired)
  );

  assign rf_ridx  = lat_idx;
  assign rf_widx  = lat_idx;
  assign rf_wdata = lat_wdata;

  // Outputs are registered alongside the state, so each is loaded with the
  // value that belongs to the state being entered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b0;
      halt_req  <= 1'b0;
      rf_wen    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      lat_write <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
    end else begin
      rf_wen <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            lat_write <= cmd_write;
            lat_idx   <= cmd_idx;
            lat_wdata <= cmd_wdata;
            cmd_ready <= 1'b0;
            halt_req  <= 1'b1;
            state     <= ST_HALT;
          end
        end
        ST_HALT: begin
          // An ack in the final allowed cycle still wins over the timeout.
          if (halt_ack) begin
            rf_wen <= lat_write && !is_zero_idx(lat_idx);
            state  <= ST_ACCESS;
          end else if (expired) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= ST_RESP;
          end
        end
        ST_ACCESS: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= (lat_write || is_zero_idx(lat_idx)) ? '0 : rf_rdata;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            halt_req  <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/dbg_gpr_access.md
DBG_GPR_ACCESS -- requirements
Module: dbg_gpr_access

Interface
REQ-001 The block SHALL have these parameters: XLEN, 64, register data width; HALT_TIMEOUT, 255, maximum HALT cycles to wait for halt_ack (range 1..255).
REQ-002 The block SHALL have these ports: clock  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 cmd_valid  in  1  debug command present; cmd_ready  out  1  command accepted when both are high.
REQ-005 cmd_write  in  1  1 = write GPR, 0 = read GPR; cmd_idx  in  5  GPR index; cmd_wdata  in  XLEN  write data.
REQ-006 rsp_valid  out  1  response present; rsp_ready  in  1  response consumed when both are high.
REQ-007 rsp_rdata  out  XLEN  read data (0 for writes and errors); rsp_err  out  1  halt timeout occurred.
REQ-008 halt_req  out  1  core stall request; halt_ack  in  1  core halted, writeback quiescent.
REQ-009 rf_ridx  out  5  regfile combinational read index; rf_rdata  in  XLEN  regfile read data, same cycle.
REQ-010 rf_wen  out  1  regfile write strobe; rf_widx  out  5  write index; rf_wdata  out  XLEN  write data.

Function
REQ-011 The FSM SHALL have states IDLE, HALT, ACCESS, RESP.
REQ-012 cmd_ready SHALL be 1 only in IDLE; on accept, cmd_write, cmd_idx and cmd_wdata SHALL be latched and the FSM SHALL enter HALT.
REQ-013 halt_req SHALL be 1 in HALT, ACCESS and RESP, and 0 in IDLE.
REQ-014 In HALT, halt_ack=1 SHALL move the FSM to ACCESS on the next edge; this check precedes the timeout check.
REQ-015 An 8-bit wait counter SHALL clear on entry to HALT and increment each HALT cycle with halt_ack=0; reaching HALT_TIMEOUT SHALL move the FSM to RESP with rsp_err=1, rsp_rdata=0 and no regfile access.
REQ-016 ACCESS SHALL last exactly one cycle, with rf_ridx and rf_widx = latched idx.
REQ-017 In ACCESS for a write, rf_wen SHALL be 1 for that single cycle, with rf_wdata = latched wdata.
REQ-018 In ACCESS for a read, rf_rdata SHALL be captured into rsp_rdata at the end of the cycle.
REQ-019 Index 0 SHALL be handled as follows: a write SHALL produce no rf_wen and rsp_err=0; a read SHALL return 0 regardless of rf_rdata.
REQ-020 rf_wen SHALL be 0 in every state other than ACCESS.
REQ-021 In RESP, rsp_valid SHALL be 1 and rsp_rdata and rsp_err SHALL be held stable until rsp_ready=1; the handshake edge SHALL return the FSM to IDLE.
REQ-022 Minimum latency SHALL be: accept at cycle T, HALT at T+1, ACCESS at T+2 (halt_ack high at T+1), rsp_valid at T+3.
REQ-023 If halt_ack deasserts during ACCESS or RESP, the operation SHALL complete unchanged.
REQ-024 A cmd_valid present in RESP SHALL wait; no back-to-back command bypass exists.

Reset
REQ-025 On reset assertion, independent of clock, the FSM SHALL go to IDLE and the outputs SHALL be: halt_req=0, rf_wen=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, cmd_ready=0.
REQ-026 The first edge after reset deassertion SHALL set cmd_ready=1.
REQ-027 Reset in ACCESS SHALL suppress rf_wen in that same cycle; a pending response SHALL be discarded.

Structure
REQ-028 Package dbg_pkg SHALL hold the state enum, XLEN default and GPR index width (5).
REQ-029 The wait counter SHALL be a sub-module dbg_halt_timer (inputs clear and enable; output expired).
REQ-030 The block SHALL hold no regfile storage; it drives an existing regfile write port and read port.

Verification
REQ-031 Scenario: write idx 5, data 0xDEAD_BEEF_0000_0001, halt_ack=1 from the start -> rf_wen pulses once at T+2 with idx 5 and that data; rsp_valid at T+3 with rsp_err=0.
REQ-032 Scenario: read idx 10 with rf_rdata=0x1234 and halt_ack delayed 7 cycles -> ACCESS is entered after the 7th HALT cycle; rsp_rdata=0x1234.
REQ-033 Scenario: write idx 0 then read idx 0 with rf_rdata=0xFFFF -> no rf_wen, read returns 0, rsp_err=0 on both.
REQ-034 Scenario: HALT_TIMEOUT=4 and halt_ack held 0 -> RESP after 4 HALT cycles with rsp_err=1, rsp_rdata=0, and no rf_wen.
REQ-035 Scenario: rsp_ready held 0 for 10 cycles while cmd_valid=1 -> rsp_valid and rsp_rdata are stable, cmd_ready=0, and halt_req=1 throughout; the next command is accepted one cycle after the handshake.
REQ-036 Scenario: reset asserted in ACCESS of a write -> no rf_wen, and halt_req=0 immediately; the FSM is in IDLE after deassertion.
